// File: rtl/eq_mac_scheduler.sv
// eq_mac_scheduler: time-multiplexed FIR equalizer sharing a single 16x16
// multiplier and a wide accumulator across all taps.
// Optional build macro EQ_OUT_SAT_EN: clamp the output to the 16-bit signed
// range instead of wrapping it.
module eq_mac_scheduler #(
   parameter int NTAPS = 31,
   parameter int FRAC  = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] symb_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [4:0]  coef_addr,
   output logic        coef_rd,
   input  logic [15:0] coef_data,
   output logic [15:0] symb_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   localparam int ACC_W = 40;
   localparam logic [4:0] LAST_IDX = 5'(NTAPS - 1);

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [15:0] sample_buf [NTAPS];
   logic [4:0] wr_ptr;
   logic [4:0] rd_ptr;
   logic [4:0] tap_cnt;
   logic signed [15:0] tap_sample;
   logic prod_pend;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [31:0] product;
   logic [15:0] result;
   logic [15:0] out_q;

   // State register; reset aborts any computation in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake/strobe outputs, all decoded from the current state
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      coef_rd    = 1'b0;
      coef_addr  = 5'd0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_next = MAC;
            end
         end
         MAC: begin
            coef_rd   = 1'b1;
            coef_addr = tap_cnt;
            if (tap_cnt == LAST_IDX) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Shared multiplier; the product lands one cycle after its coefficient read
   always_comb begin
      product = $signed(coef_data) * tap_sample;
      acc_sum = acc;
      if (prod_pend) begin
         acc_sum = acc + {{(ACC_W-32){product[31]}}, product};
      end
   end

`ifdef EQ_OUT_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
   logic signed [ACC_W-1:0] shifted;

   // Scale down by the coefficient fraction and clamp to the output range
   always_comb begin
      shifted = acc_sum >>> FRAC;
      if (shifted > SAT_MAX) begin
         result = 16'h7fff;
      end else if (shifted < SAT_MIN) begin
         result = 16'h8000;
      end else begin
         result = shifted[15:0];
      end
   end
`else
   // Scale down by the coefficient fraction and keep the low 16 bits (wraps)
   always_comb begin
      result = acc_sum[FRAC+15:FRAC];
   end
`endif

   // Delay line, tap walk and accumulation; newest sample is tap 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= 5'd0;
         rd_ptr     <= 5'd0;
         tap_cnt    <= 5'd0;
         tap_sample <= 16'sd0;
         prod_pend  <= 1'b0;
         acc        <= '0;
         out_q      <= 16'd0;
         for (int i = 0; i < NTAPS; i++) begin
            sample_buf[i] <= 16'd0;
         end
      end else begin
         prod_pend <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sample_buf[wr_ptr] <= symb_in;
                  rd_ptr  <= wr_ptr;
                  wr_ptr  <= (wr_ptr == LAST_IDX) ? 5'd0 : wr_ptr + 5'd1;
                  tap_cnt <= 5'd0;
                  acc     <= '0;
               end
            end
            MAC: begin
               tap_sample <= $signed(sample_buf[rd_ptr]);
               prod_pend  <= 1'b1;
               rd_ptr     <= (rd_ptr == 5'd0) ? LAST_IDX : rd_ptr - 5'd1;
               tap_cnt    <= tap_cnt + 5'd1;
               acc        <= acc_sum;
            end
            DRAIN: begin
               acc   <= acc_sum;
               out_q <= result;
            end
            default: begin
            end
         endcase
      end
   end

   assign symb_out = out_q;

endmodule
